nn_inference_sdiv_11s_6ns_11_seq: RTL and testbench

//  Iterative divider undoing the nn_inference 11s x 6ns fixed-point scale: 11-bit signed

---
 rtl/nn_inference_div_pkg.sv | 35 +++
 rtl/nn_inference_div_step.sv | 38 +++
 rtl/nn_inference_sdiv_11s_6ns_11_seq.sv | 166 ++++++++++++++++
 tb/tb_nn_inference_sdiv_11s_6ns_11_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_inference_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_inference_div_pkg
// Purpose  : Shared types and constants for the nn_inference 11s / 6ns
//            iterative signed divider (FSM states, iteration count,
//            remainder width and divide-by-zero saturation values).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nn_inference_div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One quotient bit per iteration, one iteration per dividend bit
    localparam int DIV_ITERS = 11;
    localparam int CNT_W     = 4;

    // Remainder accumulator width; the partial remainder is always below
    // twice the largest divisor (2*63), so 7 bits are enough.
    localparam int REM_W     = 7;

    // Divisor width
    localparam int DIVR_W    = 6;

    // Quotient reported for a zero divisor, by dividend sign
    localparam logic signed [10:0] Q_POS_SAT = 11'sd1023;
    localparam logic signed [10:0] Q_NEG_SAT = -11'sd1024;

endpackage : nn_inference_div_pkg
`default_nettype wire

// File: rtl/nn_inference_div_step.sv
`default_nettype none
// ============================================================================
// Module   : nn_inference_div_step
// Purpose  : One combinational restoring-division step. Shifts the next
//            dividend bit into the partial remainder and subtracts the
//            divisor when it fits.
// Ports    : i_rem_in   - partial remainder from previous step (< divisor)
//            i_next_bit - next dividend magnitude bit, MSB first
//            i_div      - unsigned divisor
//            o_rem_out  - updated partial remainder
//            o_q_bit    - quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module nn_inference_div_step
    import nn_inference_div_pkg::*;
(
    input  logic [REM_W-2:0]  i_rem_in,
    input  logic              i_next_bit,
    input  logic [DIVR_W-1:0] i_div,
    output logic [REM_W-1:0]  o_rem_out,
    output logic              o_q_bit
);

    logic [REM_W-1:0] w_shift;
    logic [REM_W-1:0] w_div_ext;
    logic             w_fits;

    // The incoming remainder is below the divisor (at most 62), so it fits
    // in REM_W-1 bits and the shifted value always fits in REM_W bits.
    assign w_shift   = {i_rem_in, i_next_bit};
    assign w_div_ext = {1'b0, i_div};
    assign w_fits    = (w_shift >= w_div_ext);

    assign o_q_bit   = w_fits;
    assign o_rem_out = w_fits ? (w_shift - w_div_ext) : w_shift;

endmodule : nn_inference_div_step
`default_nettype wire

// File: rtl/nn_inference_sdiv_11s_6ns_11_seq.sv
`default_nettype none
// ============================================================================
// Module   : nn_inference_sdiv_11s_6ns_11_seq
// Purpose  : Sequential signed divider, 11-bit signed dividend by 6-bit
//            unsigned divisor, truncating toward zero. One quotient bit per
//            ce-active cycle; result strobed 12 cycles after accept.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-low reset
//            ce       - clock enable, low freezes all state
//            start    - request, accepted when start & ready & ce
//            din0     - signed dividend
//            din1     - unsigned divisor
//            ready    - high when a new request can be accepted
//            dout_vld - one-cycle strobe when quotient/remainder/dbz update
//            dout_quo - signed quotient
//            dout_rem - signed remainder, sign follows dividend
//            dbz      - divide-by-zero flag for the current result
// Revision : 1.0 - initial release
// ============================================================================
module nn_inference_sdiv_11s_6ns_11_seq
    import nn_inference_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 11,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 11
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  dout_vld,
    output logic [dout_WIDTH-1:0] dout_quo,
    output logic [REM_W-1:0]      dout_rem,
    output logic                  dbz
);

    // Instance tag only; carries no function
    logic w_unused_id;
    assign w_unused_id = (ID == 0);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_ready;
    logic                    w_accept;

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sign;
    logic [din0_WIDTH-1:0]   r_mag;
    logic [din1_WIDTH-1:0]   r_div;
    logic [REM_W-1:0]        r_rem_acc;
    logic [dout_WIDTH-1:0]   r_q;

    logic [dout_WIDTH-1:0]   r_quo;
    logic [REM_W-1:0]        r_rem;
    logic                    r_dbz;
    logic                    r_vld;

    logic [din0_WIDTH-1:0]   w_abs;
    logic [REM_W-1:0]        w_step_rem;
    logic                    w_step_q;

    // Two's-complement negate in the same width; read as unsigned this
    // gives |-1024| = 1024 correctly.
    assign w_abs = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;

    nn_inference_div_step u_step (
        .i_rem_in   (r_rem_acc[REM_W-2:0]),
        .i_next_bit (r_mag[din0_WIDTH-1]),
        .i_div      (r_div),
        .o_rem_out  (w_step_rem),
        .o_q_bit    (w_step_q)
    );

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (start) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_ready      = 1'b1;
                w_next_state = start ? CALC : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept = start & w_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_div     <= '0;
            r_rem_acc <= '0;
            r_q       <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dbz     <= 1'b0;
            r_vld     <= 1'b0;
        end else if (ce) begin
            r_state <= w_next_state;
            r_vld   <= 1'b0;

            case (r_state)
                CALC: begin
                    r_rem_acc <= w_step_rem;
                    r_q       <= {r_q[dout_WIDTH-2:0], w_step_q};
                    r_mag     <= {r_mag[din0_WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt - 1'b1;
                end
                DONE: begin
                    r_vld <= 1'b1;
                    if (r_div == '0) begin
                        r_dbz <= 1'b1;
                        r_quo <= r_sign ? Q_NEG_SAT : Q_POS_SAT;
                        r_rem <= '0;
                    end else begin
                        r_dbz <= 1'b0;
                        r_quo <= r_sign ? (-r_q) : r_q;
                        r_rem <= r_sign ? (-r_rem_acc) : r_rem_acc;
                    end
                end
                default: begin
                end
            endcase

            // Loading a new operation in DONE overrides the working registers
            // after the finished result has been taken from them above.
            if (w_accept) begin
                r_sign    <= din0[din0_WIDTH-1];
                r_mag     <= w_abs;
                r_div     <= din1;
                r_rem_acc <= '0;
                r_q       <= '0;
                r_cnt     <= CNT_W'(DIV_ITERS - 1);
            end
        end
    end

    assign ready    = w_ready;
    assign dout_vld = r_vld;
    assign dout_quo = r_quo;
    assign dout_rem = r_rem;
    assign dbz      = r_dbz;

endmodule : nn_inference_sdiv_11s_6ns_11_seq
`default_nettype wire

// File: tb/tb_nn_inference_sdiv_11s_6ns_11_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_inference_sdiv_11s_6ns_11_seq
// Purpose  : Self-checking bench for the sequential signed divider, using a
//            C-style truncating division model plus directed handshake,
//            stall, reset and back-to-back scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_inference_sdiv_11s_6ns_11_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [10:0] din0;
    logic [5:0]  din1;
    logic        ready;
    logic        dout_vld;
    logic [10:0] dout_quo;
    logic [6:0]  dout_rem;
    logic        dbz;

    int n_tests;
    int n_fail;

    nn_inference_sdiv_11s_6ns_11_seq #(
        .ID         (1),
        .din0_WIDTH (11),
        .din1_WIDTH (6),
        .dout_WIDTH (11)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .start    (start),
        .din0     (din0),
        .din1     (din1),
        .ready    (ready),
        .dout_vld (dout_vld),
        .dout_quo (dout_quo),
        .dout_rem (dout_rem),
        .dbz      (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // C semantics: truncate toward zero, remainder takes dividend's sign
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int d);
        if (b == 0) begin
            d = 1;
            r = 0;
            q = (a < 0) ? -1024 : 1023;
        end else begin
            d = 0;
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic signed [31:0] quo_s();
        return 32'($signed(dout_quo));
    endfunction

    function automatic logic signed [31:0] rem_s();
        return 32'($signed(dout_rem));
    endfunction

    task automatic check_result(input string tag, input int a, input int b);
        int q, r, d;
        model(a, b, q, r, d);
        chk({tag, ".quo"}, quo_s(), q);
        chk({tag, ".rem"}, rem_s(), r);
        chk({tag, ".dbz"}, 32'(dbz), d);
    endtask

    // Present a request just after an edge; returns once it has been taken
    task automatic accept(input int a, input int b);
        din0  = a[10:0];
        din1  = b[5:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after accept until dout_vld; 0 means it never came
    task automatic wait_vld(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (dout_vld) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        int n;
        logic [10:0] held_quo;
        accept(a, b);
        din0 = 11'h555;
        din1 = 6'h2a;
        wait_vld(n);
        chk({tag, ".latency"}, n, 12);
        check_result(tag, a, b);
        chk({tag, ".ready"}, 32'(ready), 1);
        held_quo = dout_quo;
        @(posedge clk); #1;
        chk({tag, ".strobe"}, 32'(dout_vld), 0);
        chk({tag, ".hold"}, 32'(dout_quo), 32'(held_quo));
    endtask

    initial begin
        int n;
        int vld_cnt;
        int first_vld;
        int a, b;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        ce      = 1'b1;
        start   = 1'b0;
        din0    = '0;
        din1    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(ready), 1);
        chk("rst.vld",   32'(dout_vld), 0);
        chk("rst.quo",   32'(dout_quo), 0);
        chk("rst.rem",   32'(dout_rem), 0);
        chk("rst.dbz",   32'(dbz), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
        run_op("d100_7",   100,   7);
        run_op("dm100_7",  -100,  7);
        run_op("dm1024_1", -1024, 1);
        run_op("d1023_63", 1023,  63);
        run_op("d5_0",     5,     0);
        run_op("dm5_0",    -5,    0);
        run_op("d7_2",     7,     2);
        run_op("d1023_1",  1023,  1);
        run_op("d0_9",     0,     9);

        // Requests while busy are ignored; operands may change after accept
        accept(100, 7);
        vld_cnt   = 0;
        first_vld = 0;
        for (int i = 1; i <= 30; i++) begin
            start = (i == 3 || i == 7);
            din0  = 11'd555;
            din1  = 6'd3;
            @(posedge clk); #1;
            start = 1'b0;
            if (dout_vld) begin
                vld_cnt++;
                if (first_vld == 0) begin
                    first_vld = i;
                    check_result("busy", 100, 7);
                end
            end
        end
        chk("busy.vld_count", vld_cnt, 1);
        chk("busy.latency",   first_vld, 12);

        // Back-to-back: accept in DONE, second result 12 cycles after first
        accept(1023, 63);
        repeat (11) @(posedge clk);
        #1;
        chk("b2b.ready_done", 32'(ready), 1);
        din0  = 11'(-300);
        din1  = 6'd13;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.vld1", 32'(dout_vld), 1);
        check_result("b2b.first", 1023, 63);
        wait_vld(n);
        chk("b2b.gap", n, 12);
        check_result("b2b.second", -300, 13);

        // Clock-enable stall mid-calculation
        accept(-100, 7);
        repeat (4) @(posedge clk);
        #1;
        ce = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall.vld",   32'(dout_vld), 0);
        chk("stall.ready", 32'(ready), 0);
        ce = 1'b1;
        wait_vld(n);
        chk("stall.latency", (n == 0) ? 0 : (n + 9), 17);
        check_result("stall", -100, 7);

        // Reset mid-operation after a non-zero result is showing
        run_op("pre_rst", 100, 7);
        accept(200, 9);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst.quo",   32'(dout_quo), 0);
        chk("arst.rem",   32'(dout_rem), 0);
        chk("arst.dbz",   32'(dbz), 0);
        chk("arst.ready", 32'(ready), 1);
        chk("arst.vld",   32'(dout_vld), 0);
        @(negedge clk);
        reset   = 1'b1;
        vld_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dout_vld) vld_cnt++;
        end
        chk("arst.no_vld", vld_cnt, 0);
        run_op("post_rst", -77, 5);

        // Randomized operations against the model
        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 2047)) - 1024;
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 63));
            run_op("rand", a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nn_inference_sdiv_11s_6ns_11_seq
`default_nettype wire
